// File: rtl/wb_cmd_master_if.sv
// ============================================================================
// Module   : wb_if
// Brief    : Classic Wishbone bus bundle with master and slave views.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface wb_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) ();
   logic [ADDR_WIDTH-1:0]   ADR;
   logic                    CYC;
   logic [DATA_WIDTH-1:0]   DAT_W;
   logic [DATA_WIDTH/8-1:0] SEL;
   logic                    STB;
   logic                    WE;
   logic                    ACK;
   logic                    ERR;
   logic [DATA_WIDTH-1:0]   DAT_R;

   modport master (
      output ADR, CYC, DAT_W, SEL, STB, WE,
      input  ACK, ERR, DAT_R
   );

   modport slave (
      input  ADR, CYC, DAT_W, SEL, STB, WE,
      output ACK, ERR, DAT_R
   );
endinterface

`default_nettype wire

// File: rtl/wb_cmd_master.sv
// ============================================================================
// Module   : wb_cmd_master
// Brief    : Turns valid/ready commands into single classic Wishbone cycles
//            and returns data/status on a valid/ready response port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_cmd_master #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                    clk,
   input  logic                    rstn,
   wb_if.master                    m,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_we,
   input  logic [ADDR_WIDTH-1:0]   cmd_adr,
   input  logic [DATA_WIDTH-1:0]   cmd_dat,
   input  logic [DATA_WIDTH/8-1:0] cmd_sel,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_dat,
   output logic [1:0]              rsp_status,
   output logic [15:0]             err_count
);

   localparam int c_TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [c_TO_W-1:0] c_TO_LAST = (TIMEOUT > 0) ? c_TO_W'(TIMEOUT - 1) : '0;

   localparam logic [1:0] c_ST_OK  = 2'b00;
   localparam logic [1:0] c_ST_ERR = 2'b01;
   localparam logic [1:0] c_ST_TMO = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_RSP  = 2'd2
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;

   logic [ADDR_WIDTH-1:0]   r_adr;
   logic [DATA_WIDTH-1:0]   r_dat_w;
   logic [DATA_WIDTH/8-1:0] r_sel;
   logic                    r_we;
   logic                    r_cyc;
   logic [c_TO_W-1:0]       r_to_cnt;
   logic                    r_rsp_valid;
   logic [DATA_WIDTH-1:0]   r_rsp_dat;
   logic [1:0]              r_rsp_status;
   logic [15:0]             r_err_count;

   logic                    w_cmd_fire;
   logic                    w_bus_done;
   logic                    w_timeout;
   logic [1:0]              w_status_nxt;
   logic [DATA_WIDTH-1:0]   w_rsp_dat_nxt;

   assign w_timeout = (TIMEOUT != 0) && (r_to_cnt == c_TO_LAST);

   // ERR beats ACK, and a completing slave beats the timeout.
   always_comb begin
      w_state_nxt   = r_state;
      w_cmd_fire    = 1'b0;
      w_bus_done    = 1'b0;
      w_status_nxt  = c_ST_OK;
      w_rsp_dat_nxt = '0;
      case (r_state)
         ST_IDLE: begin
            if (cmd_valid) begin
               w_cmd_fire  = 1'b1;
               w_state_nxt = ST_BUS;
            end
         end
         ST_BUS: begin
            if (m.ERR) begin
               w_bus_done   = 1'b1;
               w_status_nxt = c_ST_ERR;
            end else if (m.ACK) begin
               w_bus_done    = 1'b1;
               w_rsp_dat_nxt = r_we ? '0 : m.DAT_R;
            end else if (w_timeout) begin
               w_bus_done   = 1'b1;
               w_status_nxt = c_ST_TMO;
            end
            if (w_bus_done) begin
               w_state_nxt = ST_RSP;
            end
         end
         ST_RSP: begin
            if (rsp_ready) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_adr        <= '0;
         r_dat_w      <= '0;
         r_sel        <= '0;
         r_we         <= 1'b0;
         r_cyc        <= 1'b0;
         r_to_cnt     <= '0;
         r_rsp_valid  <= 1'b0;
         r_rsp_dat    <= '0;
         r_rsp_status <= c_ST_OK;
         r_err_count  <= '0;
      end else begin
         if (w_cmd_fire) begin
            r_adr    <= cmd_adr;
            r_dat_w  <= cmd_dat;
            r_sel    <= cmd_sel;
            r_we     <= cmd_we;
            r_cyc    <= 1'b1;
            r_to_cnt <= '0;
         end
         if (r_state == ST_BUS) begin
            if (w_bus_done) begin
               r_cyc        <= 1'b0;
               r_rsp_valid  <= 1'b1;
               r_rsp_dat    <= w_rsp_dat_nxt;
               r_rsp_status <= w_status_nxt;
               if ((w_status_nxt != c_ST_OK) && (r_err_count != 16'hFFFF)) begin
                  r_err_count <= r_err_count + 16'd1;
               end
            end else if (TIMEOUT != 0) begin
               r_to_cnt <= r_to_cnt + c_TO_W'(1);
            end
         end
         if ((r_state == ST_RSP) && rsp_ready) begin
            r_rsp_valid <= 1'b0;
         end
      end
   end

   assign m.ADR      = r_adr;
   assign m.DAT_W    = r_dat_w;
   assign m.SEL      = r_sel;
   assign m.WE       = r_we;
   assign m.CYC      = r_cyc;
   assign m.STB      = r_cyc;

   assign cmd_ready  = (r_state == ST_IDLE);
   assign rsp_valid  = r_rsp_valid;
   assign rsp_dat    = r_rsp_dat;
   assign rsp_status = r_rsp_status;
   assign err_count  = r_err_count;

endmodule

`default_nettype wire

// File: tb/tb_wb_cmd_master.sv
// ============================================================================
// Module   : tb_wb_cmd_master
// Brief    : Directed self-checking bench for wb_cmd_master (TIMEOUT = 4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_wb_cmd_master;

   logic        clk = 1'b0;
   logic        rstn;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_we;
   logic [31:0] cmd_adr;
   logic [31:0] cmd_dat;
   logic [3:0]  cmd_sel;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_dat;
   logic [1:0]  rsp_status;
   logic [15:0] err_count;

   int total = 0;
   int bad   = 0;
   int ncyc;

   wb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   wb_cmd_master #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .TIMEOUT    (4)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .m          (bus),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_we     (cmd_we),
      .cmd_adr    (cmd_adr),
      .cmd_dat    (cmd_dat),
      .cmd_sel    (cmd_sel),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_dat    (rsp_dat),
      .rsp_status (rsp_status),
      .err_count  (err_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issues one command from a negedge in IDLE and plays a slave that answers
   // after wait_n wait states (mode 0 none, 1 ACK, 2 ERR, 3 ACK+ERR).
   // Returns at the negedge of the first cycle after BUS.
   task automatic do_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int wait_n, input int mode,
                         input logic [31:0] rdat, output int bus_cycles);
      cmd_valid = 1'b1;
      cmd_we    = we;
      cmd_adr   = adr;
      cmd_dat   = dat;
      cmd_sel   = sel;
      @(posedge clk);
      @(negedge clk);
      cmd_valid  = 1'b0;
      cmd_dat    = 32'h0BAD_0BAD;
      bus_cycles = 0;
      for (int i = 0; i < 50; i++) begin
         if (!bus.CYC) break;
         bus_cycles++;
         chk("bus_adr", bus.ADR, adr);
         chk("bus_we", {31'd0, bus.WE}, {31'd0, we});
         chk("bus_dat_w", bus.DAT_W, dat);
         chk("bus_stb", {31'd0, bus.STB}, 32'd1);
         bus.DAT_R = rdat;
         bus.ACK   = (mode == 1 || mode == 3) && (i == wait_n);
         bus.ERR   = (mode == 2 || mode == 3) && (i == wait_n);
         @(negedge clk);
      end
      bus.ACK = 1'b0;
      bus.ERR = 1'b0;
   endtask

   task automatic chk_rsp(input string tag, input logic [31:0] dat, input logic [1:0] st,
                          input logic [15:0] errs);
      chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
      chk({tag, "_dat"}, rsp_dat, dat);
      chk({tag, "_status"}, {30'd0, rsp_status}, {30'd0, st});
      chk({tag, "_errcnt"}, {16'd0, err_count}, {16'd0, errs});
      chk({tag, "_cyc"}, {31'd0, bus.CYC}, 32'd0);
   endtask

   initial begin
      rstn      = 1'b0;
      cmd_valid = 1'b0;
      cmd_we    = 1'b0;
      cmd_adr   = '0;
      cmd_dat   = '0;
      cmd_sel   = '0;
      rsp_ready = 1'b1;
      bus.ACK   = 1'b0;
      bus.ERR   = 1'b0;
      bus.DAT_R = '0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);

      chk("rst_cyc", {31'd0, bus.CYC}, 32'd0);
      chk("rst_stb", {31'd0, bus.STB}, 32'd0);
      chk("rst_we", {31'd0, bus.WE}, 32'd0);
      chk("rst_adr", bus.ADR, 32'd0);
      chk("rst_dat_w", bus.DAT_W, 32'd0);
      chk("rst_sel", {28'd0, bus.SEL}, 32'd0);
      chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_dat", rsp_dat, 32'd0);
      chk("rst_rsp_status", {30'd0, rsp_status}, 32'd0);
      chk("rst_errcnt", {16'd0, err_count}, 32'd0);

      // zero-wait write; ACK held high beforehand must not matter outside BUS
      bus.ACK = 1'b1;
      @(negedge clk);
      chk("idle_ack_ignored", {31'd0, rsp_valid}, 32'd0);
      bus.ACK = 1'b0;
      do_cmd(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 0, 1, 32'h5555_AAAA, ncyc);
      chk("wr_bus_cycles", ncyc, 32'd1);
      chk("wr_sel", {28'd0, bus.SEL}, 32'hF);
      chk_rsp("wr", 32'd0, 2'b00, 16'd0);
      @(negedge clk);
      chk("wr_cmd_ready_back", {31'd0, cmd_ready}, 32'd1);
      chk("wr_rsp_valid_low", {31'd0, rsp_valid}, 32'd0);

      // read with 3 wait states
      do_cmd(1'b0, 32'h104, 32'd0, 4'hF, 3, 1, 32'h12345678, ncyc);
      chk("rd_bus_cycles", ncyc, 32'd4);
      chk_rsp("rd", 32'h12345678, 2'b00, 16'd0);
      @(negedge clk);

      // slave never responds -> timeout after exactly 4 BUS cycles
      do_cmd(1'b0, 32'h108, 32'd0, 4'hF, 0, 0, 32'hFFFF_0000, ncyc);
      chk("tmo_bus_cycles", ncyc, 32'd4);
      chk_rsp("tmo", 32'd0, 2'b10, 16'd1);
      @(negedge clk);

      // ACK in the 4th cycle beats the timeout
      do_cmd(1'b0, 32'h10C, 32'd0, 4'hF, 3, 1, 32'h0BEE_F00D, ncyc);
      chk("ack4_bus_cycles", ncyc, 32'd4);
      chk_rsp("ack4", 32'h0BEE_F00D, 2'b00, 16'd1);
      @(negedge clk);

      // ERR on a read
      do_cmd(1'b0, 32'h110, 32'd0, 4'hF, 1, 2, 32'hCAFE_F00D, ncyc);
      chk("err_bus_cycles", ncyc, 32'd2);
      chk_rsp("err", 32'd0, 2'b01, 16'd2);
      @(negedge clk);

      // ACK and ERR together: ERR wins
      do_cmd(1'b0, 32'h114, 32'd0, 4'hF, 0, 3, 32'hCAFE_F00D, ncyc);
      chk("both_bus_cycles", ncyc, 32'd1);
      chk_rsp("both", 32'd0, 2'b01, 16'd3);
      @(negedge clk);

      // back-pressure with a new command waiting
      rsp_ready = 1'b0;
      do_cmd(1'b0, 32'h118, 32'd0, 4'hF, 1, 1, 32'hA5A5_0F0F, ncyc);
      chk("bp_bus_cycles", ncyc, 32'd2);
      cmd_valid = 1'b1;
      cmd_we    = 1'b1;
      cmd_adr   = 32'h200;
      cmd_dat   = 32'h11223344;
      cmd_sel   = 4'h3;
      for (int k = 0; k < 10; k++) begin
         chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
         chk("bp_rsp_dat", rsp_dat, 32'hA5A5_0F0F);
         chk("bp_rsp_status", {30'd0, rsp_status}, 32'd0);
         chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
         chk("bp_cyc", {31'd0, bus.CYC}, 32'd0);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      chk("bp_release_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("bp_release_cyc", {31'd0, bus.CYC}, 32'd0);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("bp_next_cyc", {31'd0, bus.CYC}, 32'd1);
      chk("bp_next_adr", bus.ADR, 32'h200);
      chk("bp_next_sel", {28'd0, bus.SEL}, 32'h3);
      bus.ACK = 1'b1;
      @(negedge clk);
      bus.ACK = 1'b0;
      chk_rsp("bp_next", 32'd0, 2'b00, 16'd3);
      @(negedge clk);

      // asynchronous reset in the middle of BUS
      cmd_valid = 1'b1;
      cmd_we    = 1'b0;
      cmd_adr   = 32'h300;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("ar_cyc_before", {31'd0, bus.CYC}, 32'd1);
      #2;
      rstn = 1'b0;
      #1;
      chk("ar_cyc_async", {31'd0, bus.CYC}, 32'd0);
      chk("ar_stb_async", {31'd0, bus.STB}, 32'd0);
      chk("ar_adr", bus.ADR, 32'd0);
      chk("ar_errcnt", {16'd0, err_count}, 32'd0);
      chk("ar_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("ar_no_rsp", {31'd0, rsp_valid}, 32'd0);
         chk("ar_idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      end

      // saturation of the error counter
      force dut.r_err_count = 16'hFFFF;
      @(negedge clk);
      release dut.r_err_count;
      @(negedge clk);
      chk("sat_preload", {16'd0, err_count}, 32'h0000_FFFF);
      do_cmd(1'b0, 32'h400, 32'd0, 4'hF, 1, 2, 32'h1234_0000, ncyc);
      chk("sat_bus_cycles", ncyc, 32'd2);
      chk_rsp("sat", 32'd0, 2'b01, 16'hFFFF);
      @(negedge clk);
      chk("sat_hold", {16'd0, err_count}, 32'h0000_FFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/wb_cmd_master.md
# wb_cmd_master

Active Wishbone master that turns single commands from a valid/ready request port into classic (non-pipelined) Wishbone cycles on a `wb_if.master` port, then returns the result on a valid/ready response port. It drives the same master-side signals that an idle stub ties off, and sits upstream of a slave or interconnect port. It lets DMA engines, debug bridges and test sequencers issue bus accesses without implementing Wishbone themselves. It provides a bus-timeout guard and a saturating error counter.

## Interface
- ADDR_WIDTH, 32, width of command address and `m.ADR`
- DATA_WIDTH, 32, width of write/read data; must be a multiple of 8
- TIMEOUT, 255, maximum number of bus cycles to wait for ACK/ERR; 0 disables the timeout
- clk  in  1  sole clock; all state is updated on the rising edge
- rstn  in  1  asynchronous, active-low reset
- m  wb_if.master  –  drives ADR, CYC, DAT_W, SEL, STB, WE; samples ACK, ERR, DAT_R
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_we  in  1  1 = write, 0 = read
- cmd_adr  in  ADDR_WIDTH  byte address
- cmd_dat  in  DATA_WIDTH  write data
- cmd_sel  in  DATA_WIDTH/8  byte lane selects
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_dat  out  DATA_WIDTH  read data; 0 for writes, errors and timeouts
- rsp_status  out  2  00 = OK, 01 = bus ERR, 10 = timeout, 11 = unused
- err_count  out  16  saturating count of non-OK responses

## Operation
- FSM states: IDLE, BUS, RSP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid && cmd_ready, register cmd_adr, cmd_dat, cmd_sel and cmd_we into the m.* outputs.
  - Clear the timeout counter and go to BUS.
- BUS:
  - m.CYC = m.STB = 1; ADR, DAT_W, SEL and WE stay stable for the whole state.
  - On an edge where ACK or ERR is sampled high, go to RSP.
    - ACK: status 00; rsp_dat = DAT_R for reads, 0 for writes.
    - ERR: status 01; rsp_dat = 0.
    - ACK and ERR both high: ERR wins (status 01).
  - Otherwise, if TIMEOUT != 0 and the counter equals TIMEOUT−1: go to RSP with status 10 and rsp_dat = 0. Otherwise increment the counter.
- RSP:
  - m.CYC = m.STB = 0; rsp_valid = 1 with data and status held stable.
  - On rsp_ready, go to IDLE.
- err_count increments by 1 on entry to RSP when status != 00. It saturates at 0xFFFF and never wraps.
- cmd_ready is low in BUS and RSP. Only one transaction is outstanding at a time.
- ACK and ERR are ignored outside BUS.
- Reset values: state IDLE, CYC/STB/WE = 0, ADR/DAT_W/SEL = 0, cmd_ready = 1 once rstn is high, rsp_valid = 0, rsp_dat = 0, rsp_status = 00, err_count = 0.
- Reset asserted mid-transaction forces CYC/STB low immediately (asynchronously). No response is produced for the aborted command.

## Timing
- All outputs are registered except cmd_ready, which is decoded from the state.
- The command handshake at edge E0 puts CYC/STB high for the cycle after E0.
- With a zero-wait slave (ACK high in the first BUS cycle), sampled at edge E1:
  - CYC/STB are low and rsp_valid is high in the cycle after E1.
  - If rsp_ready is high in that cycle, cmd_ready is high in the following cycle.
- Minimum throughput: 1 transaction per 3 cycles.
- Each extra slave wait state adds exactly 1 cycle of BUS.
- Timeout: BUS lasts exactly TIMEOUT cycles when no ACK/ERR arrives.
- An ACK in the same cycle the counter reaches TIMEOUT−1 wins over the timeout (status 00).
- Back-pressure: rsp_valid stays high with stable rsp_dat/rsp_status for any number of cycles until rsp_ready. The bus stays idle meanwhile.

## Test plan
- Reset, then a write with adr 0x100, dat 0xDEADBEEF, sel 0xF to a zero-wait slave:
  - CYC/STB high for exactly 1 cycle with WE = 1, ADR = 0x100, DAT_W = 0xDEADBEEF.
  - Response is status 00, rsp_dat 0.
- Read from adr 0x104 with slave DAT_R = 0x12345678 after 3 wait states:
  - BUS lasts 4 cycles.
  - Response is rsp_dat 0x12345678, status 00; err_count stays 0.
- Slave asserts ERR (and also ACK together with ERR) on a read:
  - Response is status 01, rsp_dat 0; err_count increments by 1 per response.
- TIMEOUT = 4 with a slave that never responds:
  - CYC/STB high for exactly 4 cycles, then status 10 and err_count = 1.
  - ACK in the 4th cycle instead gives status 00.
- rsp_ready held low for 10 cycles while new commands are pending:
  - Response is stable throughout; cmd_ready stays low.
  - The next command is accepted only after the response handshake.
- rstn asserted during BUS: CYC/STB drop without waiting for a clock edge, all outputs return to their reset values, and no rsp_valid is produced. Preload err_count to 0xFFFF, then issue an ERR access: err_count stays 0xFFFF.
